// File: rtl/mole_controller.sv
// Whack-a-mole game controller: spawns one mole per enable pulse at a
// pseudo-random hole and scores whacks, misses and timeouts.
module mole_controller #(
  parameter int         WIN_EASY  = 200000000,
  parameter int         WIN_MED   = 120000000,
  parameter int         WIN_HARD  = 80000000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       CLK100MHZ,
  input  logic       n_reset,
  input  logic       enable,
  input  logic [1:0] difficulty,
  input  logic [7:0] buttons,
  output logic [7:0] mole,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAME_OVER} state_t;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0]  SEED   = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [27:0] WIN_E  = 28'(WIN_EASY);
  localparam logic [27:0] WIN_M  = 28'(WIN_MED);
  localparam logic [27:0] WIN_H  = 28'(WIN_HARD);

  state_t      state;
  logic [7:0]  btn_prev;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_next;
  logic [7:0]  edges;
  logic [2:0]  last_idx;
  logic [2:0]  cand;
  logic [2:0]  spawn_idx;
  logic [27:0] win_cnt;
  logic [27:0] win_len;
  logic [27:0] win_sel;
  logic        lit_edge;
  logic        wrong_edge;
  logic        timeout;

  always_comb begin
    edges     = buttons & ~btn_prev;
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cand      = lfsr_next[2:0];
    // Never light the same hole twice in a row.
    spawn_idx = (cand == last_idx) ? cand + 3'd1 : cand;
    case (difficulty)
      2'b00:   win_sel = WIN_E;
      2'b01:   win_sel = WIN_M;
      default: win_sel = WIN_H;
    endcase
    lit_edge   = |(edges & mole);
    wrong_edge = |(edges & ~mole);
    timeout    = (win_cnt == win_len - 28'd1);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!n_reset) begin
      state      <= IDLE;
      mole       <= 8'h00;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= 8'd0;
      lives      <= 2'd3;
      game_over  <= 1'b0;
      lfsr       <= SEED;
      last_idx   <= 3'd0;
      win_cnt    <= 28'd0;
      win_len    <= WIN_E;
      // Buttons held through reset must not register as a press.
      btn_prev   <= 8'hFF;
    end else begin
      btn_prev   <= buttons;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            lfsr     <= lfsr_next;
            last_idx <= spawn_idx;
            mole     <= 8'h01 << spawn_idx;
            win_cnt  <= 28'd0;
            win_len  <= win_sel;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A lit-hole press wins over wrong presses and the timeout.
          if (lit_edge) begin
            hit_pulse <= 1'b1;
            if (score != 8'hFF) score <= score + 8'd1;
            mole  <= 8'h00;
            state <= IDLE;
          end else if (wrong_edge || timeout) begin
            miss_pulse <= 1'b1;
            lives      <= lives - 2'd1;
            mole       <= 8'h00;
            if (lives == 2'd1) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (win_cnt != 28'hFFFFFFF) begin
            win_cnt <= win_cnt + 28'd1;
          end
        end
        GAME_OVER: begin
          mole      <= 8'h00;
          game_over <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_controller.sv
// Self-checking bench for mole_controller against a transaction-level game model.
module tb_mole_controller;

  localparam logic [7:0] SEED = 8'hA5;

  logic       CLK100MHZ;
  logic       n_reset;
  logic       enable;
  logic [1:0] difficulty;
  logic [7:0] buttons;
  logic [7:0] mole;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  // Game model
  logic [7:0] m_lfsr;
  logic [2:0] m_last;
  int         m_score;
  int         m_lives;
  bit         m_over;
  int         cur_idx;
  int         cur_win;
  logic [7:0] prev_mole;

  mole_controller #(
    .WIN_EASY(20), .WIN_MED(12), .WIN_HARD(8), .LFSR_SEED(SEED)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .n_reset(n_reset), .enable(enable),
    .difficulty(difficulty), .buttons(buttons), .mole(mole),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .lives(lives), .game_over(game_over)
  );

  initial begin
    CLK100MHZ = 1'b0;
    forever #5 CLK100MHZ = ~CLK100MHZ;
  end

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic int pred_idx(input logic [7:0] l, input logic [2:0] last);
    logic [7:0] n;
    logic [2:0] c;
    n = lfsr_adv(l);
    c = n[2:0];
    if (c == last) c = c + 3'd1;
    return int'(c);
  endfunction

  function automatic int win_of(input logic [1:0] d);
    return (d == 2'b00) ? 20 : (d == 2'b01) ? 12 : 8;
  endfunction

  task automatic do_reset(input logic [7:0] hold);
    n_reset = 1'b0; enable = 1'b0; difficulty = 2'b00; buttons = hold;
    step(); step();
    n_reset = 1'b1;
    m_lfsr = SEED; m_last = 3'd0; m_score = 0; m_lives = 3; m_over = 0;
    prev_mole = 8'h01;
  endtask

  task automatic spawn(input logic [1:0] d);
    logic [7:0] exp_m;
    enable = 1'b1; difficulty = d;
    step();
    enable = 1'b0;
    cur_idx = pred_idx(m_lfsr, m_last);
    m_lfsr  = lfsr_adv(m_lfsr);
    m_last  = 3'(cur_idx);
    cur_win = win_of(d);
    exp_m = 8'(1 << cur_idx);
    checks++;
    if (mole !== exp_m) begin
      failures++; $display("FAIL spawn_mole got=%h exp=%h", mole, exp_m);
    end
    checks++;
    if (mole === prev_mole) begin
      failures++; $display("FAIL spawn_repeat got=%h prev=%h", mole, prev_mole);
    end
    checks++;
    if ({hit_pulse, miss_pulse} !== 2'b00) begin
      failures++; $display("FAIL spawn_pulses got=%b exp=00", {hit_pulse, miss_pulse});
    end
    prev_mole = exp_m;
  endtask

  // Plays out the current mole: press mask applied on ACTIVE cycle act_k (-1: none).
  task automatic play_mole(input int act_k, input logic [7:0] press, input bit noise);
    int out_k;
    bit is_hit;
    logic [7:0] lit;
    lit = 8'(1 << cur_idx);
    if (act_k >= 0 && act_k < cur_win && press != 8'h00) begin
      out_k = act_k; is_hit = press[cur_idx];
    end else begin
      out_k = cur_win - 1; is_hit = 0;
    end
    for (int k = 0; k <= out_k; k++) begin
      if (k > 0) begin
        checks++;
        if (mole !== lit || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
          failures++;
          $display("FAIL active_k%0d mole=%h hit=%b miss=%b exp_mole=%h", k, mole, hit_pulse, miss_pulse, lit);
        end
      end
      buttons = (k == act_k) ? press : 8'h00;
      if (noise) begin
        enable = 1'($urandom_range(0, 1));
        difficulty = 2'($urandom_range(0, 3));
      end
      step();
    end
    buttons = 8'h00; enable = 1'b0;
    if (is_hit) begin
      if (m_score < 255) m_score++;
    end else begin
      m_lives--;
      if (m_lives == 0) m_over = 1;
    end
    checks++;
    if (hit_pulse !== is_hit || miss_pulse !== !is_hit) begin
      failures++; $display("FAIL outcome hit=%b miss=%b exp_hit=%b", hit_pulse, miss_pulse, is_hit);
    end
    checks++;
    if (mole !== 8'h00 || score !== 8'(m_score) || lives !== 2'(m_lives) || game_over !== m_over) begin
      failures++;
      $display("FAIL after_outcome mole=%h score=%0d lives=%0d go=%b exp score=%0d lives=%0d go=%b",
               mole, score, lives, game_over, m_score, m_lives, m_over);
    end
    step();
    checks++;
    if ({hit_pulse, miss_pulse} !== 2'b00) begin
      failures++; $display("FAIL pulse_width got=%b exp=00", {hit_pulse, miss_pulse});
    end
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    checks++;
    if (mole !== 8'h00 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_outputs mole=%h hit=%b miss=%b", mole, hit_pulse, miss_pulse);
    end
    checks++;
    if (score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0) begin
      failures++; $display("FAIL reset_counts score=%0d lives=%0d go=%b exp 0/3/0", score, lives, game_over);
    end
  endtask

  task automatic test_timeout();
    do_reset(8'h00);
    spawn(2'b00);
    play_mole(-1, 8'h00, 0);
  endtask

  task automatic test_hit();
    do_reset(8'h00);
    spawn(2'b00);
    play_mole(3, 8'(1 << cur_idx), 0);
  endtask

  task automatic test_simultaneous();
    logic [7:0] lit;
    do_reset(8'h00);
    spawn(2'b01);
    lit = 8'(1 << cur_idx);
    play_mole(2, lit | 8'(1 << ((cur_idx + 3) % 8)), 0);
    spawn(2'b01);
    play_mole(1, 8'(1 << ((cur_idx + 5) % 8)), 0);
    // Hit landing on the last visible cycle still counts as a hit.
    spawn(2'b10);
    play_mole(7, 8'(1 << cur_idx), 0);
  endtask

  task automatic test_game_over();
    do_reset(8'h00);
    spawn(2'b10);
    play_mole(0, 8'(1 << cur_idx), 0);
    for (int i = 0; i < 3; i++) begin
      spawn(2'b10);
      play_mole(-1, 8'h00, 0);
    end
    for (int i = 0; i < 10; i++) begin
      enable  = 1'($urandom_range(0, 1));
      buttons = 8'($urandom_range(0, 255));
      step();
      checks++;
      if (mole !== 8'h00 || score !== 8'(m_score) || lives !== 2'd0 || game_over !== 1'b1
          || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
        failures++;
        $display("FAIL game_over_frozen mole=%h score=%0d lives=%0d go=%b exp score=%0d",
                 mole, score, lives, game_over, m_score);
      end
    end
    enable = 1'b0; buttons = 8'h00;
  endtask

  task automatic test_hold_reset();
    int pidx;
    logic [7:0] lit;
    pidx = pred_idx(SEED, 3'd0);
    lit = 8'(1 << pidx);
    do_reset(lit);
    spawn(2'b00);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (hit_pulse !== 1'b0 || mole !== lit) begin
        failures++; $display("FAIL held_no_hit k=%0d hit=%b mole=%h exp_mole=%h", k, hit_pulse, mole, lit);
      end
    end
    buttons = 8'h00;
    step();
    buttons = lit;
    step();
    m_score++;
    checks++;
    if (hit_pulse !== 1'b1 || score !== 8'(m_score) || mole !== 8'h00) begin
      failures++; $display("FAIL repress_hit hit=%b score=%0d mole=%h exp 1/%0d/00", hit_pulse, score, mole, m_score);
    end
    buttons = 8'h00;
    step();
    // Reset in the middle of a live mole.
    spawn(2'b00);
    step(); step(); step();
    n_reset = 1'b0;
    step();
    checks++;
    if (mole !== 8'h00 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || score !== 8'd0 || lives !== 2'd3) begin
      failures++;
      $display("FAIL reset_mid_active mole=%h hit=%b miss=%b score=%0d lives=%0d", mole, hit_pulse, miss_pulse, score, lives);
    end
    n_reset = 1'b1;
    m_lfsr = SEED; m_last = 3'd0; m_score = 0; m_lives = 3; m_over = 0; prev_mole = 8'h01;
    step();
    checks++;
    if ({hit_pulse, miss_pulse} !== 2'b00) begin
      failures++; $display("FAIL post_reset_pulses got=%b exp=00", {hit_pulse, miss_pulse});
    end
  endtask

  task automatic test_random();
    int gap, act, k;
    logic [7:0] press;
    do_reset(8'h00);
    for (int n = 0; n < 100; n++) begin
      if (m_over) do_reset(8'h00);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        buttons = 8'($urandom_range(0, 255));
        step();
        checks++;
        if (mole !== 8'h00 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
          failures++; $display("FAIL idle_ignore mole=%h hit=%b miss=%b", mole, hit_pulse, miss_pulse);
        end
      end
      buttons = 8'h00;
      spawn(2'($urandom_range(0, 3)));
      act = $urandom_range(0, 2);
      k = $urandom_range(0, cur_win - 1);
      if (act == 0) begin
        play_mole(-1, 8'h00, 1);
      end else if (act == 1) begin
        press = 8'(1 << cur_idx) | 8'($urandom_range(0, 255));
        play_mole(k, press, 1);
      end else begin
        press = 8'(1 << ((cur_idx + $urandom_range(1, 7)) % 8));
        play_mole(k, press, 1);
      end
    end
  endtask

  initial begin
    n_reset = 1'b0; enable = 1'b0; difficulty = 2'b00; buttons = 8'h00;
    test_reset();
    test_timeout();
    test_hit();
    test_simultaneous();
    test_game_over();
    test_hold_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
MOLE_CONTROLLER -- requirements
Module: mole_controller

Interface
REQ-001 Parameter WIN_EASY, default 200000000; mole visible window in clock cycles for difficulty 2'b00.
REQ-002 Parameter WIN_MED, default 120000000; window for difficulty 2'b01.
REQ-003 Parameter WIN_HARD, default 80000000; window for difficulty 2'b10 and 2'b11.
REQ-004 Parameter LFSR_SEED, default 8'hA5; LFSR reset value, with 8'h00 replaced by 8'h01.
REQ-005 Port CLK100MHZ  input  1  single system clock; all logic on its rising edge.
REQ-006 Port n_reset  input  1  reset; synchronous, active-low.
REQ-007 Port enable  input  1  one-cycle spawn request pulse from the periodic trigger.
REQ-008 Port difficulty  input  2  game difficulty; sampled only at spawn.
REQ-009 Port buttons  input  8  debounced, synchronous button levels; bit i is hole i.
REQ-010 Port mole  output  8  one-hot lit hole, or all zero when no mole is shown.
REQ-011 Port hit_pulse  output  1  one-cycle pulse on a successful whack.
REQ-012 Port miss_pulse  output  1  one-cycle pulse on a timeout or a wrong button.
REQ-013 Port score  output  8  hit count, unsigned.
REQ-014 Port lives  output  2  remaining lives.
REQ-015 Port game_over  output  1  high while in GAME_OVER.

Function
REQ-016 States SHALL be IDLE, ACTIVE and GAME_OVER; all outputs SHALL be registered.
REQ-017 Button edge detection SHALL be edge = buttons & ~btn_prev, with btn_prev <= buttons every cycle in all states.
REQ-018 The LFSR SHALL be 8-bit Fibonacci, shifting left, with feedback lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] into bit 0; it SHALL advance only on an accepted spawn.
REQ-019 IDLE with enable=1 SHALL transition to ACTIVE on the next edge:
  - candidate index = next-LFSR[2:0];
  - if the candidate equals the last index, use (candidate+1) mod 8;
  - mole = 1<<index, last index = index;
  - window counter = 0; window length latched from difficulty.
REQ-020 In ACTIVE the window counter SHALL increment by 1 per cycle and saturate at 28 bits.
REQ-021 ACTIVE, edge on the lit bit: next cycle hit_pulse=1, score+1 (saturating at 255), mole=0, state=IDLE.
REQ-022 ACTIVE, edge on any unlit bit with no edge on the lit bit: next cycle miss_pulse=1, lives-1, mole=0.
REQ-023 ACTIVE, no hit and counter == window-1: the same miss action as REQ-022 (timeout); visible time = window cycles exactly.
REQ-024 Simultaneous events in ACTIVE:
  - an edge on the lit bit wins over wrong edges and over timeout in the same cycle;
  - hit on the final window cycle = hit.
REQ-025 After a miss, state SHALL be IDLE if new lives > 0, else GAME_OVER.
REQ-026 enable SHALL be ignored in ACTIVE and GAME_OVER (no queuing); buttons SHALL be ignored in IDLE and GAME_OVER.
REQ-027 GAME_OVER: mole=0, game_over=1, score and lives frozen; exit only via reset.
REQ-028 hit_pulse and miss_pulse SHALL never both be high, and each SHALL last exactly one cycle.
REQ-029 difficulty changes while ACTIVE SHALL NOT affect the current window.

Reset
REQ-030 When n_reset=0 at a clock edge:
  - state=IDLE; mole=0; hit_pulse=0; miss_pulse=0;
  - score=0; lives=3; game_over=0;
  - LFSR=seed; last index=0; window counter=0;
  - btn_prev=8'hFF, so buttons held through reset produce no edge.
REQ-031 Reset asserted mid-ACTIVE SHALL abort the mole with no hit or miss pulse and no score or lives change.

Verification (WIN_EASY=20, WIN_MED=12, WIN_HARD=8)
REQ-032 Reset, difficulty=00, enable pulse, no buttons -> mole one-hot for exactly 20 cycles, then miss_pulse, lives=2.
REQ-033 Spawn, then press the lit button on cycle 3 -> hit_pulse next cycle, score=1, mole=0, lives=3.
REQ-034 Spawn, press a wrong button and the lit button in the same cycle -> hit only, score=1; then a wrong button alone on the next mole -> miss, lives=2.
REQ-035 Three consecutive timeouts -> lives=0, game_over=1; further enable pulses and buttons leave mole=0 and score unchanged.
REQ-036 100 spawns with random difficulty -> never the same index twice in a row; window length matches the difficulty latched at spawn; enable during ACTIVE changes nothing.
REQ-037 Hold the lit button through reset, then spawn on that hole -> no hit until release and re-press; reset mid-ACTIVE -> no pulses, score=0, lives=3.
